// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: NUM_CH-channel PWM, shared period/prescaler, shadowed duty committed at wrap
module pwm_multi_channel #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         en_out,
  input  logic [NUM_CH-1:0]         en_pwm,
  input  logic [PRESC_W-1:0]        prescale,
  input  logic [CNT_W-1:0]          period,
  input  logic                      duty_wr_en,
  input  logic [$clog2(NUM_CH)-1:0] duty_wr_ch,
  input  logic [CNT_W-1:0]          duty_wr_data,
  output logic [NUM_CH-1:0]         out,
  output logic                      period_start
);
  localparam int CH_W = $clog2(NUM_CH);
  logic [PRESC_W-1:0] presc_cnt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   shadow [NUM_CH];
  logic [CNT_W-1:0]   active [NUM_CH];
  logic               tick;
  logic               wrap;
  logic               wr_ok;
  logic [NUM_CH-1:0]  wr_sel;
  logic [NUM_CH-1:0]  raw;
  // tick/wrap decode; comparisons use >= so lowering prescale/period takes effect next step
  always_comb begin
    tick  = presc_cnt >= prescale;
    wrap  = tick && (cnt >= period);
    wr_ok = duty_wr_en && (32'(duty_wr_ch) < 32'(NUM_CH));
    wr_sel = '0;
    raw    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_ok && (duty_wr_ch == CH_W'(i));
      raw[i]    = (active[i] == '1) || (cnt < active[i]);
    end
  end
  // prescaler: restart after reaching the divide value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_cnt <= '0;
    else presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
  end
  // period counter and registered wrap pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (tick) cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end
  // duty shadows take writes; actives reload at wrap, with a coincident write bypassing the shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_sel[i]) shadow[i] <= duty_wr_data;
        if (wrap) active[i] <= wr_sel[i] ? duty_wr_data : shadow[i];
      end
    end
  end
  // registered outputs: disabled -> low, static mode -> high, else PWM compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else out <= en_out & ((en_pwm & raw) | ~en_pwm);
  end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: directed checks of duty, period, prescale, commit timing and reset
module tb_pwm_multi_channel;
  localparam int NCH = 12;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NCH-1:0]  en_out = '1;
  logic [NCH-1:0]  en_pwm = '1;
  logic [7:0]      prescale = 8'd0;
  logic [7:0]      period = 8'd9;
  logic            duty_wr_en = 1'b0;
  logic [3:0]      duty_wr_ch = '0;
  logic [7:0]      duty_wr_data = '0;
  logic [NCH-1:0]  out;
  logic            period_start;
  int              checks = 0;
  int              errors = 0;
  int              hi [NCH];
  int              ps;
  int              tot;
  logic [NCH-1:0]  det_out;
  logic [NCH-1:0]  first_out;

  pwm_multi_channel #(.NUM_CH(NCH), .CNT_W(8), .PRESC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en_out(en_out), .en_pwm(en_pwm),
    .prescale(prescale), .period(period), .duty_wr_en(duty_wr_en),
    .duty_wr_ch(duty_wr_ch), .duty_wr_data(duty_wr_data),
    .out(out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_duty(input logic [3:0] ch, input logic [7:0] data);
    @(negedge clk);
    duty_wr_ch = ch;
    duty_wr_data = data;
    duty_wr_en = 1'b1;
    @(negedge clk);
    duty_wr_en = 1'b0;
  endtask

  // wait for a period_start, then sample len cycles; optionally drive one write after sample wr_at
  task automatic measure(input int len, input int wr_at, input logic [3:0] wch, input logic [7:0] wdata);
    int n;
    n = 0;
    ps = 0;
    for (int c = 0; c < NCH; c++) hi[c] = 0;
    do begin
      @(negedge clk);
      duty_wr_en = 1'b0;
      n++;
    end while (!period_start && n < 2000);
    if (!period_start) chk("ps_timeout", 0, 1);
    det_out = out;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      duty_wr_en = 1'b0;
      if (k == 1) first_out = out;
      for (int c = 0; c < NCH; c++) hi[c] += int'(out[c]);
      ps += int'(period_start);
      if (k == wr_at) begin
        duty_wr_ch = wch;
        duty_wr_data = wdata;
        duty_wr_en = 1'b1;
      end
    end
  endtask

  initial begin
    en_out[7] = 1'b0;
    en_pwm[6] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(out), 0);
    chk("rst_ps", 32'(period_start), 0);
    rst_n = 1'b1;
    write_duty(0, 8'd3);
    write_duty(1, 8'd2);
    write_duty(2, 8'd2);
    write_duty(3, 8'd0);
    write_duty(4, 8'd10);
    write_duty(5, 8'hFF);
    write_duty(7, 8'd5);
    write_duty(8, 8'd2);
    measure(10, -1, 0, 0);
    for (int p = 0; p < 2; p++) begin
      measure(10, -1, 0, 0);
      chk("t1_hi0", hi[0], 3);
      chk("t1_ps", ps, 1);
    end
    chk("t1_det0", 32'(det_out[0]), 0);
    chk("t1_rise0", 32'(first_out[0]), 1);
    chk("t4_duty0", hi[3], 0);
    chk("t4_duty10", hi[4], 10);
    chk("t4_dutyff", hi[5], 10);
    chk("t4_static", hi[6], 10);
    chk("t4_disabled", hi[7], 0);
    chk("t1_hi1", hi[1], 2);
    measure(10, 4, 4'd2, 8'd7);
    chk("t3_keep", hi[2], 2);
    chk("t3_ps", ps, 1);
    measure(10, -1, 0, 0);
    chk("t3_new", hi[2], 7);
    chk("t3_rise", 32'(first_out[2]), 1);
    measure(10, 3, 4'd12, 8'd9);
    measure(10, -1, 0, 0);
    chk("t5_oor0", hi[0], 3);
    chk("t5_oor3", hi[3], 0);
    chk("t5_oor8", hi[8], 2);
    measure(9, 9, 4'd8, 8'd6);
    chk("t5_pre_byp", hi[8], 2);
    measure(10, -1, 0, 0);
    chk("t5_bypass", hi[8], 6);
    @(negedge clk);
    prescale = 8'd3;
    period = 8'd4;
    measure(20, -1, 0, 0);
    measure(20, -1, 0, 0);
    chk("t2_hi1", hi[1], 8);
    chk("t2_hi0", hi[0], 12);
    chk("t2_hi4", hi[4], 20);
    chk("t2_ps", ps, 1);
    @(negedge clk);
    prescale = 8'd0;
    period = 8'd255;
    measure(256, -1, 0, 0);
    measure(256, -1, 0, 0);
    chk("t4_ff_full", hi[5], 256);
    chk("t4_ten_p255", hi[4], 10);
    chk("t4_ps255", ps, 1);
    @(negedge clk);
    period = 8'd9;
    measure(10, -1, 0, 0);
    measure(5, -1, 0, 0);
    chk("t6_pre6", 32'(out[6]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_out", 32'(out), 0);
    chk("t6_async_ps", 32'(period_start), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en_pwm = '1;
    measure(25, -1, 0, 0);
    tot = 0;
    for (int c = 0; c < NCH; c++) tot += hi[c];
    chk("t6_all_low", tot, 0);
    chk("t6_ps", ps, 2);
    write_duty(0, 8'd4);
    measure(10, -1, 0, 0);
    measure(10, -1, 0, 0);
    chk("t6_recommit", hi[0], 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
